// File: rtl/rng_result_capture_if.sv
// ---------------------------------------------------------------------------
// rng_result_capture_if
// Purpose: Bundles the start/random inputs and the result/statistics outputs
//          of the random-number result capture block. The LFSR generator's
//          button pulse and random nibble come in, and the captured result,
//          history and roll statistics go out.
// Signals:
//    i_start         start/pause pulse, one cycle wide
//    i_random[3:0]   generator random output
//    o_busy          rolling or paused
//    o_paused        paused
//    o_result[3:0]   last captured result
//    o_result_valid  one-cycle pulse on capture
//    o_repeat        capture equals the previous capture
//    o_history[15:0] last four results, newest in [3:0]
//    o_roll_count    completed rolls, wrapping
// Modports:
//    master  drives i_start/i_random and observes the results
//    slave   the capture block itself
// ---------------------------------------------------------------------------
interface rng_result_capture_if;
   logic        i_start;
   logic [3:0]  i_random;
   logic        o_busy;
   logic        o_paused;
   logic [3:0]  o_result;
   logic        o_result_valid;
   logic        o_repeat;
   logic [15:0] o_history;
   logic [7:0]  o_roll_count;

   modport master (
      output i_start, i_random,
      input  o_busy, o_paused, o_result, o_result_valid, o_repeat,
             o_history, o_roll_count
   );

   modport slave (
      input  i_start, i_random,
      output o_busy, o_paused, o_result, o_result_valid, o_repeat,
             o_history, o_roll_count
   );
endinterface

// File: rtl/rng_result_capture.sv
// ---------------------------------------------------------------------------
// rng_result_capture
// Purpose: Consumer end of the LFSR random-number generator. It follows the
//          same start/pause pulses the generator sees, waits for the random
//          output to stay quiet for SETTLE_CYCLES rolling cycles, and then
//          latches that value as the final result. It also keeps a four-entry
//          result history, a wrapping roll counter and a repeat flag.
// Parameters:
//    SETTLE_CYCLES  quiet rolling cycles needed to declare a result final
//    CNT_W          quiet counter width, must hold SETTLE_CYCLES-1
// Ports:
//    i_clk   clock, all logic on the rising edge
//    i_rst   synchronous active-high reset
//    bus     rng_result_capture_if.slave (start/random in, results out)
// ---------------------------------------------------------------------------
module rng_result_capture #(
   parameter int SETTLE_CYCLES = 67108864,
   parameter int CNT_W         = 27
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   rng_result_capture_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROLL  = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_t           state_q,       state_d;
   logic [CNT_W-1:0] quietCnt_q,    quietCnt_d;
   logic [3:0]       prevSample_q,  prevSample_d;
   logic [3:0]       result_q,      result_d;
   logic [15:0]      history_q,     history_d;
   logic [7:0]       rollCount_q,   rollCount_d;
   logic             repeat_q,      repeat_d;
   logic             havePrev_q,    havePrev_d;

   // State and datapath registers. Reset aborts any roll in progress and
   // clears every visible output, including the history and statistics.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= IDLE;
         quietCnt_q   <= '0;
         prevSample_q <= '0;
         result_q     <= '0;
         history_q    <= '0;
         rollCount_q  <= '0;
         repeat_q     <= 1'b0;
         havePrev_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         quietCnt_q   <= quietCnt_d;
         prevSample_q <= prevSample_d;
         result_q     <= result_d;
         history_q    <= history_d;
         rollCount_q  <= rollCount_d;
         repeat_q     <= repeat_d;
         havePrev_q   <= havePrev_d;
      end
   end

   // Next-state and capture logic. Everything holds by default; the repeat
   // flag defaults low so it only survives for the single DONE cycle that
   // follows a capture. Within ROLL a start pulse wins over a settle on the
   // same cycle, so pausing exactly at the settle point never captures.
   // While paused the quiet count is frozen, and on resume the current
   // random value becomes the new reference without restarting the count.
   always_comb begin
      state_d      = state_q;
      quietCnt_d   = quietCnt_q;
      prevSample_d = prevSample_q;
      result_d     = result_q;
      history_d    = history_q;
      rollCount_d  = rollCount_q;
      repeat_d     = 1'b0;
      havePrev_d   = havePrev_q;

      case (state_q)
         IDLE: begin
            if (bus.i_start) begin
               state_d      = ROLL;
               quietCnt_d   = '0;
               prevSample_d = bus.i_random;
            end
         end

         ROLL: begin
            if (bus.i_start) begin
               state_d = PAUSE;
            end else if (bus.i_random != prevSample_q) begin
               quietCnt_d   = '0;
               prevSample_d = bus.i_random;
            end else if (quietCnt_q == SETTLE_LAST) begin
               state_d     = DONE;
               result_d    = prevSample_q;
               history_d   = {history_q[11:0], prevSample_q};
               rollCount_d = rollCount_q + 8'd1;
               repeat_d    = havePrev_q && (prevSample_q == history_q[3:0]);
               havePrev_d  = 1'b1;
            end else begin
               quietCnt_d = quietCnt_q + CNT_W'(1);
            end
         end

         PAUSE: begin
            if (bus.i_start) begin
               state_d      = ROLL;
               prevSample_d = bus.i_random;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Status outputs decode directly from the state register; the valid
   // pulse is simply the one-cycle DONE state.
   assign bus.o_busy         = (state_q == ROLL) || (state_q == PAUSE);
   assign bus.o_paused       = (state_q == PAUSE);
   assign bus.o_result_valid = (state_q == DONE);
   assign bus.o_result       = result_q;
   assign bus.o_repeat       = repeat_q;
   assign bus.o_history      = history_q;
   assign bus.o_roll_count   = rollCount_q;

endmodule

// File: tb/tb_rng_result_capture.sv
// ---------------------------------------------------------------------------
// tb_rng_result_capture
// Purpose: Self-checking bench for rng_result_capture with a short settle
//          time. A behavioural model tracks the roll in terms of "quiet
//          rolling cycles seen so far" and keeps the captured results in a
//          queue; history, count and repeat are derived from that queue.
// ---------------------------------------------------------------------------
module tb_rng_result_capture;

   localparam int SETTLE = 8;

   logic clk;
   logic rstSig;
   int   compared;
   int   mismatched;

   rng_result_capture_if busIf ();

   rng_result_capture #(
      .SETTLE_CYCLES (SETTLE),
      .CNT_W         (4)
   ) dut (
      .i_clk (clk),
      .i_rst (rstSig),
      .bus   (busIf)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model state: whether a roll is active or paused, how many
   // quiet rolling cycles have passed since the value last moved, the value
   // being watched, and every captured result (newest at the back).
   bit       mRolling;
   bit       mPaused;
   bit       mDone;
   bit       mRepeat;
   int       mQuiet;
   int       mWatched;
   int       mRolls;
   int       mLastResult;
   int       mResults[$];

   function automatic logic [15:0] expHistory();
      logic [15:0] h;
      int n;
      h = '0;
      n = mResults.size();
      for (int i = 0; i < 4; i++) begin
         if (i < n) h = h | (16'(mResults[n-1-i]) << (4 * i));
      end
      return h;
   endfunction

   // Advance the model by one clock edge using the inputs present at it.
   task automatic modelStep(input bit start, input int rnd, input bit rst);
      mRepeat = 1'b0;
      if (rst) begin
         mRolling    = 1'b0;
         mPaused     = 1'b0;
         mDone       = 1'b0;
         mQuiet      = 0;
         mWatched    = 0;
         mRolls      = 0;
         mLastResult = 0;
         mResults.delete();
      end else if (mDone) begin
         mDone = 1'b0;
      end else if (mPaused) begin
         if (start) begin
            mPaused  = 1'b0;
            mRolling = 1'b1;
            mWatched = rnd;
         end
      end else if (mRolling) begin
         if (start) begin
            mRolling = 1'b0;
            mPaused  = 1'b1;
         end else if (rnd != mWatched) begin
            mWatched = rnd;
            mQuiet   = 0;
         end else begin
            mQuiet = mQuiet + 1;
            if (mQuiet == SETTLE) begin
               mRepeat     = (mResults.size() > 0) && (mResults[$] == mWatched);
               mResults.push_back(mWatched);
               if (mResults.size() > 4) void'(mResults.pop_front());
               mLastResult = mWatched;
               mRolls      = (mRolls + 1) % 256;
               mRolling    = 1'b0;
               mDone       = 1'b1;
            end
         end
      end else if (start) begin
         mRolling = 1'b1;
         mQuiet   = 0;
         mWatched = rnd;
      end
   endtask

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   task automatic checkAll();
      checkOutput("busy",   32'(busIf.o_busy),         32'(mRolling || mPaused));
      checkOutput("paused", 32'(busIf.o_paused),       32'(mPaused));
      checkOutput("valid",  32'(busIf.o_result_valid), 32'(mDone));
      checkOutput("repeat", 32'(busIf.o_repeat),       32'(mRepeat));
      checkOutput("result", 32'(busIf.o_result),       32'(mLastResult));
      checkOutput("hist",   32'(busIf.o_history),      32'(expHistory()));
      checkOutput("count",  32'(busIf.o_roll_count),   32'(mRolls));
   endtask

   // Drive one cycle of inputs, let the edge happen, update the model and
   // compare a little after the edge.
   task automatic applyStimulus(input bit start, input int rnd, input bit rst);
      busIf.i_start  = start;
      busIf.i_random = 4'(rnd);
      rstSig         = rst;
      @(posedge clk);
      modelStep(start, rnd, rst);
      #1;
      checkAll();
   endtask

   task automatic holdValue(input int rnd, input int cycles);
      for (int i = 0; i < cycles; i++) applyStimulus(1'b0, rnd, 1'b0);
   endtask

   initial begin
      int rnd;
      bit st;
      compared   = 0;
      mismatched = 0;
      busIf.i_start  = 1'b0;
      busIf.i_random = 4'd0;
      rstSig         = 1'b1;

      // Reset, then idle with a toggling random value.
      applyStimulus(1'b0, 0, 1'b1);
      applyStimulus(1'b0, 0, 1'b1);
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, i % 16, 1'b0);

      // Constant value: capture 5 eight cycles after entry.
      applyStimulus(1'b1, 5, 1'b0);
      holdValue(5, 12);

      // Value moves on quiet cycle 6, restarting the settle wait.
      applyStimulus(1'b1, 3, 1'b0);
      holdValue(9, 7);
      holdValue(12, 12);

      // Pause after four quiet cycles, noise while paused, resume on 7.
      applyStimulus(1'b1, 1, 1'b0);
      holdValue(1, 4);
      applyStimulus(1'b1, 1, 1'b0);
      for (int i = 0; i < 50; i++) applyStimulus(1'b0, $urandom_range(0, 15), 1'b0);
      applyStimulus(1'b1, 7, 1'b0);
      holdValue(7, 12);

      // Two rolls both settling on 0xA from a fresh reset.
      applyStimulus(1'b0, 0, 1'b1);
      applyStimulus(1'b1, 10, 1'b0);
      holdValue(10, 10);
      applyStimulus(1'b1, 10, 1'b0);
      holdValue(10, 10);

      // Start pulse on the settle cycle pauses instead of capturing.
      applyStimulus(1'b1, 2, 1'b0);
      holdValue(2, 7);
      applyStimulus(1'b1, 2, 1'b0);
      holdValue(6, 3);
      applyStimulus(1'b1, 2, 1'b0);
      holdValue(2, 4);

      // Reset in the middle of a roll.
      applyStimulus(1'b1, 4, 1'b0);
      holdValue(4, 3);
      applyStimulus(1'b0, 4, 1'b1);
      holdValue(4, 10);

      // 256 complete rolls wrap the roll counter back to zero.
      for (int r = 0; r < 256; r++) begin
         rnd = $urandom_range(0, 15);
         applyStimulus(1'b1, rnd, 1'b0);
         holdValue(rnd, SETTLE + 1);
      end
      checkOutput("wrapCount", 32'(busIf.o_roll_count), 32'(0));

      // Random start pulses and random value changes.
      rnd = 0;
      for (int i = 0; i < 3000; i++) begin
         st = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 5) == 0) rnd = $urandom_range(0, 15);
         applyStimulus(st, rnd, ($urandom_range(0, 999) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
